// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl
//   Runs one program on the pipelined RISC-V cpu. It streams a program into
//   instruction memory over the cpu's ext port, then holds cpu enable high for a
//   programmed cycle budget. When read-back is built in, it then reads a window of
//   data memory over the cpu's second ext port and streams that window out.
//
// Build option
//   BOOT_DUMP_EN  When defined, the data-memory read-back phase is included.
//                 When undefined, the controller goes to DONE at the end of the run,
//                 and the dmem/dump outputs are tied to 0.
//
// Ports
//   clk_i          clock; all logic is on the rising edge
//   rst_i          synchronous reset, active high
//   start_i        1-cycle pulse that begins a load; honoured only in IDLE/DONE
//   run_cycles_i   cpu-enable cycle budget, latched when start is accepted
//   ld_valid_i     program word valid
//   ld_ready_o     program word accepted (high throughout LOAD)
//   ld_data_i      program word
//   ld_last_i      marks the final program word
//   imem_addr_o    byte address to the cpu addr_ext
//   imem_wen_o     write enable to the cpu wen_ext
//   imem_wdata_o   write data to the cpu wdata_ext
//   cpu_enable_o   cpu enable
//   dmem_addr_o    byte address to the cpu addr_ext_2
//   dmem_ren_o     read enable to the cpu ren_ext_2
//   dmem_rdata_i   read data from the cpu rdata_ext_2, valid 1 cycle after dmem_ren_o
//   dump_valid_o   read-back word valid
//   dump_ready_i   consumer accepts the read-back word
//   dump_data_o    read-back word
//   busy_o         state is neither IDLE nor DONE
//   done_o         high in DONE
//   err_o          program overflow; sticky until the next accepted start

module cpu_boot_ctrl #(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DUMP_WORDS = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] run_cycles_i,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [31:0]      ld_data_i,
    input  logic             ld_last_i,
    output logic [63:0]      imem_addr_o,
    output logic             imem_wen_o,
    output logic [31:0]      imem_wdata_o,
    output logic             cpu_enable_o,
    output logic [63:0]      dmem_addr_o,
    output logic             dmem_ren_o,
    input  logic [63:0]      dmem_rdata_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [63:0]      dump_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned IDX_W  = $clog2(IMEM_WORDS + 1);
    localparam int unsigned DIDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

    // Index value at which a further accepted word no longer fits in imem.
    localparam logic [IDX_W-1:0] IMEM_FULL = IDX_W'(IMEM_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDreq,
        StDwait,
        StDout,
        StDone
    } state_e;

    // Where the controller goes once the cpu-enable budget is spent (or is zero).
`ifdef BOOT_DUMP_EN
    localparam state_e StPostRun = StDreq;
    localparam logic [DIDX_W-1:0] DUMP_LAST = DIDX_W'(DUMP_WORDS - 1);
`else
    localparam state_e StPostRun = StDone;
`endif

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

`ifdef BOOT_DUMP_EN
    logic [DIDX_W-1:0] didx_q, didx_d;
    logic [63:0]       dump_data_q, dump_data_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
`ifdef BOOT_DUMP_EN
            didx_q      <= '0;
            dump_data_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`ifdef BOOT_DUMP_EN
            didx_q      <= didx_d;
            dump_data_q <= dump_data_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        ld_ready_o   = 1'b0;
        imem_addr_o  = '0;
        imem_wen_o   = 1'b0;
        imem_wdata_o = '0;
        cpu_enable_o = 1'b0;
`ifdef BOOT_DUMP_EN
        didx_d       = didx_q;
        dump_data_d  = dump_data_q;
        dmem_addr_o  = '0;
        dmem_ren_o   = 1'b0;
        dump_valid_o = 1'b0;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StLoad;
                    err_d   = 1'b0;
                    cnt_d   = run_cycles_i;
                    idx_d   = '0;
`ifdef BOOT_DUMP_EN
                    didx_d  = '0;
`endif
                end
            end

            StLoad: begin
                ld_ready_o   = 1'b1;
                imem_addr_o  = 64'({idx_q, 2'b00});
                imem_wdata_o = ld_data_i;
                if (ld_valid_i) begin
                    if (idx_q == IMEM_FULL) begin
                        // Overflow word is swallowed, not written.
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        imem_wen_o = 1'b1;
                        idx_d      = idx_q + IDX_W'(1);
                        if (ld_last_i) begin
                            state_d = (cnt_q == '0) ? StPostRun : StRun;
                        end
                    end
                end
            end

            StRun: begin
                // cnt_q is never 0 here: a zero budget skips RUN entirely.
                cpu_enable_o = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StPostRun;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

`ifdef BOOT_DUMP_EN
            StDreq: begin
                dmem_ren_o  = 1'b1;
                dmem_addr_o = 64'({didx_q, 3'b000});
                state_d     = StDwait;
            end

            StDwait: begin
                dump_data_d = dmem_rdata_i;
                state_d     = StDout;
            end

            StDout: begin
                dump_valid_o = 1'b1;
                if (dump_ready_i) begin
                    if (didx_q == DUMP_LAST) begin
                        state_d = StDone;
                    end else begin
                        didx_d  = didx_q + DIDX_W'(1);
                        state_d = StDreq;
                    end
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef BOOT_DUMP_EN
    assign dump_data_o = dump_data_q;
`else
    assign dmem_addr_o  = '0;
    assign dmem_ren_o   = 1'b0;
    assign dump_valid_o = 1'b0;
    assign dump_data_o  = '0;

    // Read-back inputs have no function in this build.
    logic unused_dump_inputs;
    assign unused_dump_inputs = ^{dmem_rdata_i, dump_ready_i};
`endif

    assign busy_o = (state_q != StIdle) && (state_q != StDone);
    assign done_o = (state_q == StDone);
    assign err_o  = err_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl
//   Randomised scoreboard bench for cpu_boot_ctrl. Stimulus tasks push the expected
//   event stream (imem writes, cpu-enable cycles, dump words, done) into a queue.
//   A monitor pops and compares whenever the DUT presents one of those events.
//   Read-back checks are active when BOOT_DUMP_EN is defined.

module tb_cpu_boot_ctrl;

    localparam int unsigned IMEM_WORDS = 512;
    localparam int unsigned DUMP_WORDS = 16;
    localparam int unsigned CNT_W      = 32;

`ifdef BOOT_DUMP_EN
    localparam bit DUMP = 1'b1;
`else
    localparam bit DUMP = 1'b0;
`endif

    localparam int EV_WR   = 0;
    localparam int EV_EN   = 1;
    localparam int EV_DUMP = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic [63:0] data;
        int          ord;
    } ev_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] run_cycles;
    logic             ld_valid;
    logic             ld_ready;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic [63:0]      imem_addr;
    logic             imem_wen;
    logic [31:0]      imem_wdata;
    logic             cpu_enable;
    logic [63:0]      dmem_addr;
    logic             dmem_ren;
    logic [63:0]      dmem_rdata;
    logic             dump_valid;
    logic             dump_ready;
    logic [63:0]      dump_data;
    logic             busy;
    logic             done;
    logic             err;

    int          n_cmp;
    int          n_bad;
    longint      cyc;
    ev_t         exp_q[$];
    logic [31:0] prog[$];
    logic [63:0] dmem[DUMP_WORDS];

    cpu_boot_ctrl #(
        .IMEM_WORDS(IMEM_WORDS),
        .DUMP_WORDS(DUMP_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .run_cycles_i(run_cycles),
        .ld_valid_i  (ld_valid),
        .ld_ready_o  (ld_ready),
        .ld_data_i   (ld_data),
        .ld_last_i   (ld_last),
        .imem_addr_o (imem_addr),
        .imem_wen_o  (imem_wen),
        .imem_wdata_o(imem_wdata),
        .cpu_enable_o(cpu_enable),
        .dmem_addr_o (dmem_addr),
        .dmem_ren_o  (dmem_ren),
        .dmem_rdata_i(dmem_rdata),
        .dump_valid_o(dump_valid),
        .dump_ready_i(dump_ready),
        .dump_data_o (dump_data),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Data-memory model: registered read, one cycle after the read enable.
    always @(posedge clk) begin
        if (dmem_ren) dmem_rdata <= dmem[int'(dmem_addr >> 3) % DUMP_WORDS];
    end

    // Consumer with random back-pressure, including occasional 5-cycle stalls.
    initial begin
        int stall;
        stall = 0;
        dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall > 0) begin
                dump_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 7) == 0) begin
                dump_ready = 1'b0;
                stall = 4;
            end else begin
                dump_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        bit          done_prev;
        bit          stall_prev;
        logic [63:0] data_prev;
        longint      en_base;
        longint      last_en;
        done_prev  = 1'b0;
        stall_prev = 1'b0;
        data_prev  = '0;
        en_base    = 0;
        last_en    = 0;
        forever begin
            @(negedge clk);
            if (imem_wen) check_event(EV_WR, imem_addr, 64'(imem_wdata), en_base, last_en);
            if (cpu_enable) check_event(EV_EN, '0, '0, en_base, last_en);
            if (stall_prev) begin
                chk("dump_valid_held", 64'(dump_valid), 64'(1));
                chk("dump_data_stable", dump_data, data_prev);
            end
            if (dump_valid && dump_ready) check_event(EV_DUMP, '0, dump_data, en_base, last_en);
            if (done && !done_prev) check_event(EV_DONE, '0, 64'(err), en_base, last_en);
            done_prev  = done;
            stall_prev = dump_valid && !dump_ready;
            data_prev  = dump_data;
        end
    end

    task automatic check_event(input int kind, input logic [63:0] addr, input logic [63:0] data,
                               inout longint en_base, inout longint last_en);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)",
                     kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        if (kind != e.kind) return;
        case (kind)
            EV_WR: begin
                chk("imem_addr", addr, e.addr);
                chk("imem_wdata", data, e.data);
            end
            EV_EN: begin
                if (e.ord == 0) en_base = cyc;
                chk("enable_consecutive", 64'(cyc - en_base), 64'(e.ord));
                last_en = cyc;
            end
            EV_DUMP: chk("dump_data", data, e.data);
            default: begin
                chk("done_err", data, e.data);
                if (e.ord == 1) chk("done_after_last_run", 64'(cyc - last_en), 64'(1));
            end
        endcase
    endtask

    function automatic void push_ev(int kind, logic [63:0] addr, logic [63:0] data, int ord);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.ord  = ord;
        exp_q.push_back(e);
    endfunction

    // Reference model: expected event stream of one complete run.
    function automatic void model_run(int n, logic [CNT_W-1:0] budget);
        bit ovf;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i >= int'(IMEM_WORDS)) begin
                ovf = 1'b1;
                break;
            end
            push_ev(EV_WR, 64'(4 * i), 64'(prog[i]), 0);
        end
        if (ovf) begin
            push_ev(EV_DONE, '0, 64'(1), 0);
            return;
        end
        for (int k = 0; k < int'(budget); k++) push_ev(EV_EN, '0, '0, k);
        if (DUMP) for (int j = 0; j < int'(DUMP_WORDS); j++) push_ev(EV_DUMP, '0, dmem[j], 0);
        push_ev(EV_DONE, '0, '0, (!DUMP && budget != 0) ? 1 : 0);
    endfunction

    // Called at posedge+1; leaves at posedge+1 with the controller in LOAD.
    task automatic do_start(input logic [CNT_W-1:0] budget);
        start      = 1'b1;
        run_cycles = budget;
        @(posedge clk);
        #1;
        start      = 1'b0;
        run_cycles = $urandom;
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("err_cleared_on_start", 64'(err), 64'(0));
        chk("ld_ready_in_load", 64'(ld_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        bit ok;
        ok       = 1'b0;
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ld_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ld_ready_timeout", 64'(ld_ready), 64'(1));
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = $urandom;
    endtask

    task automatic wait_done(input bit exp_err);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_reached", 64'(done), 64'(1));
        chk("busy_low_in_done", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("done_holds", 64'(done), 64'(1));
        chk("err_sticky", 64'(err), 64'(exp_err));
        chk("cpu_enable_low_in_done", 64'(cpu_enable), 64'(0));
        chk("dump_valid_low_in_done", 64'(dump_valid), 64'(0));
        exp_q.delete();
    endtask

    task automatic run_prog(input int n, input bit use_last, input logic [CNT_W-1:0] budget,
                            input bit gaps);
        for (int j = 0; j < int'(DUMP_WORDS); j++) dmem[j] = {$urandom, $urandom};
        model_run(n, budget);
        do_start(budget);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_word(prog[i], use_last && (i == n - 1));
        end
        wait_done(n > int'(IMEM_WORDS));
    endtask

    task automatic reset_mid_run();
        int seen;
        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back($urandom);
        for (int i = 0; i < 4; i++) push_ev(EV_WR, 64'(4 * i), 64'(prog[i]), 0);
        for (int k = 0; k < 40; k++) push_ev(EV_EN, '0, '0, k);
        do_start(40);
        send_word(prog[0], 1'b0);
        send_word(prog[1], 1'b0);
        // start during LOAD must not restart the load nor reload the budget.
        start      = 1'b1;
        run_cycles = 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("ld_ready_after_ignored_start", 64'(ld_ready), 64'(1));
        @(posedge clk);
        #1;
        send_word(prog[2], 1'b0);
        send_word(prog[3], 1'b1);
        seen = 0;
        for (int t = 0; t < 100 && seen < 5; t++) begin
            @(negedge clk);
            if (cpu_enable) seen++;
        end
        chk("run_entered", 64'(seen), 64'(5));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_cpu_enable", 64'(cpu_enable), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ld_ready", 64'(ld_ready), 64'(0));
        repeat (3) @(negedge clk);
        chk("rst_no_restart", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        run_cycles = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        dmem_rdata = '0;
        for (int j = 0; j < int'(DUMP_WORDS); j++) dmem[j] = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        chk("reset_ld_ready", 64'(ld_ready), 64'(0));
        chk("reset_imem_wen", 64'(imem_wen), 64'(0));
        chk("reset_imem_addr", imem_addr, 64'(0));
        chk("reset_cpu_enable", 64'(cpu_enable), 64'(0));
        chk("reset_dmem_ren", 64'(dmem_ren), 64'(0));
        chk("reset_dump_valid", 64'(dump_valid), 64'(0));
        chk("reset_dump_data", dump_data, 64'(0));
        @(posedge clk);
        #1;

        // Three-word program, budget 10.
        prog.delete();
        prog.push_back(32'h0000_0013);
        prog.push_back(32'h0000_0013);
        prog.push_back(32'h0010_0073);
        run_prog(3, 1'b1, 10, 1'b0);

        // Zero budget, one word.
        prog.delete();
        prog.push_back($urandom);
        run_prog(1, 1'b1, 0, 1'b0);

        // Overflow: IMEM_WORDS+1 words without ld_last.
        prog.delete();
        for (int i = 0; i <= int'(IMEM_WORDS); i++) prog.push_back($urandom);
        run_prog(IMEM_WORDS + 1, 1'b0, 7, 1'b0);

        // Reset in the middle of RUN, with a start pulse ignored during LOAD.
        reset_mid_run();

        // Randomised runs.
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 20);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            run_prog(n, 1'b1, CNT_W'($urandom_range(0, 30)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
